// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Round-robin arbiter and fixed-latency access sequencer that
//                shares a single-ported memory between the core and the UART
//                boot loader.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_ready,
    output logic                  cpu_hold,
    input  logic                  ldr_boot,
    input  logic                  ldr_req,
    input  logic                  ldr_we,
    input  logic [ADDR_WIDTH-1:0] ldr_addr,
    input  logic [DATA_WIDTH-1:0] ldr_wdata,
    output logic [DATA_WIDTH-1:0] ldr_rdata,
    output logic                  ldr_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [1:0]            owner
);

    localparam int                 c_cnt_w = $clog2(MEM_LATENCY + 1) + 1;
    localparam logic [c_cnt_w-1:0] c_lat   = c_cnt_w'(MEM_LATENCY);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);
    localparam logic [1:0]         c_g_cpu = 2'b01;
    localparam logic [1:0]         c_g_ldr = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t             r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [1:0]         r_last_grant;
    logic               r_is_write;

    logic                  w_cpu_elig;
    logic                  w_ldr_elig;
    logic [1:0]            w_pick;
    logic                  w_sel_we;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;

    // Boot mode removes the core from arbitration entirely.
    assign w_cpu_elig = cpu_req & ~ldr_boot;
    assign w_ldr_elig = ldr_req;

    always_comb begin
        w_pick = 2'b00;
        if (w_cpu_elig && w_ldr_elig) begin
            w_pick = r_last_grant[0] ? c_g_ldr : c_g_cpu;
        end else if (w_cpu_elig) begin
            w_pick = c_g_cpu;
        end else if (w_ldr_elig) begin
            w_pick = c_g_ldr;
        end
    end

    assign w_sel_we    = w_pick[1] ? ldr_we    : cpu_we;
    assign w_sel_addr  = w_pick[1] ? ldr_addr  : cpu_addr;
    assign w_sel_wdata = w_pick[1] ? ldr_wdata : cpu_wdata;

    assign cpu_hold = ldr_boot | (cpu_req & ~cpu_ready);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_last_grant <= c_g_ldr;
            r_is_write   <= 1'b0;
            owner        <= 2'b00;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            cpu_rdata    <= '0;
            ldr_rdata    <= '0;
            cpu_ready    <= 1'b0;
            ldr_ready    <= 1'b0;
        end else begin
            cpu_ready <= 1'b0;
            ldr_ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (|w_pick) begin
                        owner        <= w_pick;
                        r_last_grant <= w_pick;
                        mem_addr     <= w_sel_addr;
                        mem_wdata    <= w_sel_wdata;
                        mem_we       <= w_sel_we;
                        r_is_write   <= w_sel_we;
                        r_cnt        <= c_lat;
                        r_state      <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    // Single write strobe: only the first ACCESS cycle writes.
                    mem_we <= 1'b0;
                    if (r_cnt == '0) begin
                        if (!r_is_write) begin
                            if (owner[0]) cpu_rdata <= mem_rdata;
                            if (owner[1]) ldr_rdata <= mem_rdata;
                        end
                        cpu_ready <= owner[0];
                        ldr_ready <= owner[1];
                        r_state   <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - c_one;
                    end
                end
                S_RESP: begin
                    owner   <= 2'b00;
                    r_state <= S_IDLE;
                end
                default: begin
                    owner   <= 2'b00;
                    mem_we  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
